// File: rtl/btn_trigger.sv
// Push-button front end: two-flop synchroniser, four-state debounce FSM and
// a one-cycle trigger per accepted press, maskable by lock.
// Optional feature macro: BTN_REPEAT_EN (auto-repeat triggers while held).
module btn_trigger #(
   parameter int unsigned DEB_CMAX  = 250_000,     // 5 ms at 50 MHz
   parameter int unsigned RPT_DELAY = 25_000_000,  // 500 ms at 50 MHz
   parameter int unsigned RPT_CMAX  = 5_000_000    // 100 ms at 50 MHz
) (
   input  logic clk,
   input  logic rst,
   input  logic a_btn,
   input  logic lock,
   output logic tr_btn,
   output logic lv_btn
);

`ifdef BTN_REPEAT_EN
   localparam int unsigned RPT_MAX = (RPT_DELAY > RPT_CMAX) ? RPT_DELAY : RPT_CMAX;
   localparam int unsigned CNT_MAX = (RPT_MAX > DEB_CMAX) ? RPT_MAX : DEB_CMAX;
`else
   localparam int unsigned CNT_MAX = DEB_CMAX;
`endif
   localparam int unsigned CW = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0] DEB_LAST = CW'(DEB_CMAX - 1);
`ifdef BTN_REPEAT_EN
   localparam logic [CW-1:0] RPT_FIRST_LAST = CW'(RPT_DELAY - 1);
   localparam logic [CW-1:0] RPT_NEXT_LAST  = CW'(RPT_CMAX - 1);
`endif

   // Zero-length windows would make the last-cycle compares underflow.
   if (DEB_CMAX < 1 || RPT_DELAY < 1 || RPT_CMAX < 1) begin : g_bad_cfg
      $error("btn_trigger: DEB_CMAX, RPT_DELAY and RPT_CMAX must all be >= 1");
   end

   typedef enum logic [1:0] {StIdle, StDebDn, StHeld, StDebUp} state_e;

   state_e        state;
   logic [CW-1:0] cnt;
   logic          s1;
   logic          s2;
`ifdef BTN_REPEAT_EN
   logic          rpt_first;  // next repeat uses RPT_DELAY rather than RPT_CMAX
`endif

   // Two-flop synchroniser for the asynchronous pad level.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= a_btn;
         s2 <= s1;
      end
   end

   // Debounce FSM; cnt is cleared on every state entry and never wraps.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= StIdle;
         cnt    <= '0;
         tr_btn <= 1'b0;
         lv_btn <= 1'b0;
`ifdef BTN_REPEAT_EN
         rpt_first <= 1'b1;
`endif
      end else begin
         tr_btn <= 1'b0;
         unique case (state)
            StIdle: begin
               if (s2) begin
                  state <= StDebDn;
                  cnt   <= '0;
               end
            end
            StDebDn: begin
               if (!s2) begin
                  state <= StIdle;
                  cnt   <= '0;
               end else if (cnt == DEB_LAST) begin
                  state  <= StHeld;
                  cnt    <= '0;
                  lv_btn <= 1'b1;
                  tr_btn <= !lock;
`ifdef BTN_REPEAT_EN
                  rpt_first <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            StHeld: begin
               if (!s2) begin
                  state <= StDebUp;
                  cnt   <= '0;
               end
`ifdef BTN_REPEAT_EN
               // While held, cnt doubles as the repeat timer.
               else if (cnt == (rpt_first ? RPT_FIRST_LAST : RPT_NEXT_LAST)) begin
                  cnt       <= '0;
                  tr_btn    <= !lock;
                  rpt_first <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
`endif
            end
            StDebUp: begin
               if (s2) begin
                  // Release bounce: back to held without a trigger.
                  state <= StHeld;
                  cnt   <= '0;
`ifdef BTN_REPEAT_EN
                  rpt_first <= 1'b1;
`endif
               end else if (cnt == DEB_LAST) begin
                  state  <= StIdle;
                  cnt    <= '0;
                  lv_btn <= 1'b0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: begin
               state <= StIdle;
               cnt   <= '0;
            end
         endcase
      end
   end

endmodule
